// File: rtl/alu_pkg.sv
// alu_pkg: opcode/state types and opcode classification helpers for alu_pipe
package alu_pkg;
  typedef enum logic [3:0] {
    OP_NOTHING = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3,
    OP_DIV = 4'd4, OP_XOR = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7,
    OP_REM = 4'd8, OP_NOT = 4'd9, OP_SLL = 4'd10, OP_SRL = 4'd11,
    OP_SRA = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_RSVD = 4'd15
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
  function automatic logic is_iterative(alu_op_t op);
    return op inside {OP_MUL, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
  endfunction
  function automatic logic is_divide(alu_op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVU, OP_REMU};
  endfunction
  function automatic logic is_signed_div(alu_op_t op);
    return op inside {OP_DIV, OP_REM};
  endfunction
  function automatic logic is_remainder(alu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction
  function automatic logic zero_ext(alu_op_t op);
    return op inside {OP_SRL, OP_DIVU, OP_REMU};
  endfunction
endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring divider, one quotient bit per cycle, signed or unsigned
module alu_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);
  localparam int LG = $clog2(WIDTH);
  logic             r_run, r_qneg, r_rneg;
  logic [LG-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo, r_rem, r_div, w_quo_n, w_rem_n;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_an, w_bn, w_ge;
  assign w_an    = i_signed && i_a[WIDTH-1];
  assign w_bn    = i_signed && i_b[WIDTH-1];
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = !w_diff[WIDTH];
  assign w_rem_n = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};
  // results come straight from the final step so the caller can load them on the done edge
  assign o_done  = r_run && r_cnt == LG'(WIDTH-1);
  assign o_quo   = r_qneg ? -w_quo_n : w_quo_n;
  assign o_rem   = r_rneg ? -w_rem_n : w_rem_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_cnt  <= '0;
      r_quo  <= w_an ? -i_a : i_a;
      r_rem  <= '0;
      r_div  <= w_bn ? -i_b : i_b;
      r_qneg <= w_an ^ w_bn;
      r_rneg <= w_an;
    end else if (r_run) begin
      r_cnt <= r_cnt + 1'b1;
      r_quo <= w_quo_n;
      r_rem <= w_rem_n;
      r_run <= !o_done;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute ALU, registered single-cycle ops plus iterative mul/div
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter bit TRACE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             word,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int LG = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LO32 = WIDTH'(64'hFFFF_FFFF);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[31]) ? (x | ~LO32) : (x & LO32);
  endfunction
  state_t           r_state, w_next;
  alu_op_t          w_op, r_op;
  logic             r_word;
  logic [LG-1:0]    r_cnt, w_sh;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_prod;
  logic [WIDTH-1:0] w_a, w_b, w_alu, w_div_spec, w_mul_next, w_iter, w_load_val, w_quo, w_rem;
  logic             w_acc, w_spec, w_start_iter, w_start_mul, w_start_div, w_single;
  logic             w_last, w_load, w_div_done;
  assign w_op         = alu_op_t'(opcode);
  assign w_a          = word ? ext32(value1, !zero_ext(w_op)) : value1;
  assign w_b          = word ? ext32(value2, !zero_ext(w_op)) : value2;
  assign w_sh         = word ? LG'(value2[4:0]) : value2[LG-1:0];
  assign in_ready     = r_state == IDLE && (!out_valid || out_ready);
  assign busy         = r_state != IDLE;
  assign w_acc        = in_valid && in_ready;
  // zero divisor and signed overflow have closed-form answers and never iterate
  assign w_spec       = is_divide(w_op) && (w_b == '0 || (is_signed_div(w_op) && w_a == MIN && &w_b));
  assign w_div_spec   = w_b == '0 ? ((w_op inside {OP_DIV, OP_DIVU}) ? '1 : w_a)
                                  : (w_op == OP_DIV ? w_a : '0);
  assign w_start_iter = w_acc && is_iterative(w_op) && !w_spec;
  assign w_start_mul  = w_start_iter && w_op == OP_MUL;
  assign w_start_div  = w_start_iter && w_op != OP_MUL;
  assign w_single     = w_acc && w_op != OP_NOTHING && !w_start_iter;
  assign w_last       = r_cnt == LG'(WIDTH-1);
  assign w_mul_next   = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_iter       = r_state == MUL_RUN ? w_mul_next : (is_remainder(r_op) ? w_rem : w_quo);
  assign w_load       = w_single || (r_state == MUL_RUN && w_last) || (r_state == DIV_RUN && w_div_done);
  assign w_load_val   = w_single ? (word ? ext32(w_alu, 1'b1) : w_alu)
                                 : (r_word ? ext32(w_iter, 1'b1) : w_iter);
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_NOT:  w_alu = ~w_a;
      OP_SLL:  w_alu = w_a << w_sh;
      OP_SRL:  w_alu = w_a >> w_sh;
      OP_SRA:  w_alu = $unsigned($signed(w_a) >>> w_sh);
      OP_DIV, OP_REM, OP_DIVU, OP_REMU: w_alu = w_div_spec;
      default: w_alu = '0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start_mul ? MUL_RUN : (w_start_div ? DIV_RUN : IDLE);
      MUL_RUN: w_next = w_last ? IDLE : MUL_RUN;
      DIV_RUN: w_next = w_div_done ? IDLE : DIV_RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= OP_NOTHING;
      r_word    <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      if (w_acc) begin
        r_op     <= w_op;
        r_word   <= word;
        r_cnt    <= '0;
        r_mcand  <= w_a;
        r_mplier <= w_b;
        r_prod   <= '0;
      end else if (r_state == MUL_RUN) begin
        r_cnt    <= r_cnt + 1'b1;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_prod   <= w_mul_next;
      end
      out_valid <= w_load || (out_valid && !out_ready);
      if (w_load) result <= w_load_val;
    end
  end
  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (reset),
    .i_start  (w_start_div),
    .i_signed (is_signed_div(w_op)),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_done   (w_div_done),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );
  if (TRACE) begin : g_trace
    logic [WIDTH-1:0] r_v1, r_v2;
    always_ff @(posedge clk) begin
      if (w_acc) begin
        r_v1 <= value1;
        r_v2 <= value2;
      end
      if (out_valid && out_ready) $display("alu_pipe op=%0d a=%h b=%h result=%h", r_op, r_v1, r_v2, result);
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with hand-computed results, latency and handshake checks
module tb_alu_pipe;
  import alu_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, word = 1'b0, out_ready = 1'b1;
  logic [3:0]  opcode = '0;
  logic [63:0] value1 = '0, value2 = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(64), .TRACE(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .word      (word),
    .value1    (value1),
    .value2    (value2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int g, lat, nb, nr;
    @(negedge clk);
    opcode = op; word = w; value1 = a; value2 = b; in_valid = 1'b1; out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1; nb = 0; nr = 0;
    while (!out_valid && lat < 200) begin
      nb += int'(busy);
      nr += int'(in_ready);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".res"}, result, exp);
    if (exp_lat > 1) begin
      check({tag, ".busy_cycles"}, 64'(nb), 64'(exp_lat - 1));
      check({tag, ".ready_cycles"}, 64'(nr), 64'd0);
      check({tag, ".busy_after"}, 64'(busy), 64'd0);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int nv;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.result", result, 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    run("add", OP_ADD, 1'b0, 64'd5, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run("sub", OP_SUB, 1'b0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run("xor", OP_XOR, 1'b0, 64'hFF, 64'h0F, 64'hF0, 1);
    run("not", OP_NOT, 1'b0, 64'h0F, 64'd123, 64'hFFFF_FFFF_FFFF_FFF0, 1);
    run("sll", OP_SLL, 1'b0, 64'd1, 64'h7F, 64'h8000_0000_0000_0000, 1);
    run("sra", OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1);
    run("srlw", OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 1);
    run("addw", OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
    run("rsvd", OP_RSVD, 1'b0, 64'd9, 64'd9, 64'd0, 1);
    run("mul", OP_MUL, 1'b0, 64'd123456789, -64'sd3, -64'sd370370367, 65);
    run("div", OP_DIV, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
    run("rem", OP_REM, 1'b0, -64'sd7, 64'd2, -64'sd1, 65);
    run("rem_negdiv", OP_REM, 1'b0, 64'd7, -64'sd2, 64'd1, 65);
    run("divu", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run("divu0", OP_DIVU, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu0", OP_REMU, 1'b0, 64'd7, 64'd0, 64'd7, 1);
    run("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 1);
    @(negedge clk);
    opcode = OP_NOTHING; value1 = 64'd1; value2 = 64'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      nv += int'(out_valid);
      @(posedge clk);
      #1;
    end
    check("nothing.no_output", 64'(nv), 64'd0);
    @(negedge clk);
    opcode = OP_AND; value1 = 64'hF0F0; value2 = 64'hFF00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    opcode = OP_ADD; value1 = 64'd3; value2 = 64'd4;
    check("bp.ov", 64'(out_valid), 64'd1);
    check("bp.res", result, 64'hF000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold_ov", 64'(out_valid), 64'd1);
      check("bp.hold_res", result, 64'hF000);
      check("bp.hold_rdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    #1;
    check("bp.rdy_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp.next_ov", 64'(out_valid), 64'd1);
    check("bp.next_res", result, 64'd7);
    @(negedge clk);
    opcode = OP_DIV; value1 = 64'd1000; value2 = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.result", result, 64'd0);
    @(negedge clk) reset = 1'b0;
    #1;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    run("abort.add", OP_ADD, 1'b0, 64'd1, 64'd1, 64'd2, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the combinational execute ALU.
- Single-cycle ops (add/sub/logic/shifts, including arithmetic right shift and 32-bit word mode) return after one registered cycle.
- MUL/DIV/REM/DIVU/REMU run iteratively over WIDTH cycles.
- Sits between decode/operand-select (immediate/shamt selection happens upstream) and writeback, with valid/ready on both sides.

Parameters:
- WIDTH, 64, operand/result width; power of two, at least 32.
- TRACE, 0, when 1, $display opcode/operands/result on every output handshake.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- opcode  in  4  operation (encoding below)
- word  in  1  32-bit word mode
- value1  in  WIDTH  first operand
- value2  in  WIDTH  second operand / shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  WIDTH  registered result
- busy  out  1  iterative op in progress

Behaviour:
- Opcodes: NOTHING=0, ADD=1, SUB=2, MUL=3, DIV=4, XOR=5, AND=6, OR=7, REM=8, NOT=9, SLL=10, SRL=11, SRA=12, DIVU=13, REMU=14.
  - Opcode 15 is reserved and yields result 0 with normal 1-cycle latency.
- Reset (async): state IDLE, out_valid=0, result=0, busy=0, iteration counter 0. in_ready is 1 while reset is deasserted and the block is idle.
- States:
  - IDLE accepts requests.
  - MUL_RUN runs shift-add multiply, WIDTH iterations, 1 bit/cycle.
  - DIV_RUN runs restoring division, WIDTH iterations, on magnitudes, sign-fixed at the end.
  - Completion loads the output register and returns to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Latencies (accept in cycle N):
  - 1-cycle ops: out_valid rises in N+1.
  - Iterative ops: busy is high N+1..N+WIDTH and out_valid rises in N+WIDTH+1.
- NOTHING is accepted and produces no output.
- NOT ignores value2.
- Output register holds result stable while out_valid && !out_ready. It clears out_valid on handshake unless a new result loads in the same cycle.
- Shift amount is value2[$clog2(WIDTH)-1:0]; in word mode it is value2[4:0].
- Word mode:
  - Operands are reduced to bits [31:0]. Sign-extend for signed ops/SRA; zero-extend for SRL/DIVU/REMU.
  - Compute at WIDTH, then sign-extend result bit 31 to WIDTH.
- MUL returns the low WIDTH bits of the product.
- DIV/REM truncate toward zero; the remainder sign follows the dividend.
- Division special cases are detected at accept, skip iteration, and use 1-cycle latency:
  - Divisor 0: quotient all-ones; remainder = dividend.
  - Signed most-negative / -1: quotient = dividend; remainder 0.
- Operands are latched at accept; input changes during RUN have no effect.
- Reset mid-operation aborts immediately. Any pending result is discarded.
- Sub-module handshake: start pulse, done pulse.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_t with the encodings above
  - typedef enum state_t {IDLE, MUL_RUN, DIV_RUN}
  - helper function is_iterative(op)
- Natural sub-module: alu_divider. It is an iterative restoring divider with signed/unsigned select, start/done, and quotient and remainder outputs, parametrised by WIDTH.
- The multiplier stays inline.

Test Plan:
- ADD value1=5, value2=-7 -> result 0xFFFF_FFFF_FFFF_FFFE, out_valid exactly 1 cycle after accept.
- SRA value1=0x8000_0000_0000_0000, value2=4 -> 0xF800_0000_0000_0000.
- SRL word=1, value1=0xFFFF_FFFF_8000_0000, value2=4 -> 0x0000_0000_0800_0000.
- MUL 123456789 x -3 -> -370370367:
  - out_valid exactly 65 cycles after accept
  - busy high 64 cycles
  - in_ready low throughout
- DIV -7/2 -> -3; REM -7%2 -> -1; DIVU 7/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 7%0 -> 7. Special cases in 1 cycle.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 with 1-cycle latency.
- Backpressure: hold out_ready=0 for 3 cycles after an AND result.
  - result and out_valid stay stable; in_ready stays 0.
  - Raising out_ready with in_valid high completes the handshake and accepts the next request in the same cycle.
- Assert reset during iteration 20 of a DIV:
  - out_valid=0 and busy=0 immediately.
  - After release, ADD 1+1 -> 2 with 1-cycle latency.
